// File: rtl/seq_multiplier_32bit.sv
// Multi-cycle shift-add multiplier for MIPS mult/multu in the execute stage.
// One partial product per cycle; hi/lo update only when a product completes.
module seq_multiplier_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] inp_A,
    input  logic [WIDTH-1:0] inp_B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // state | meaning
    // IDLE  | waiting for start; hi/lo hold last product
    // RUN   | one shift-add iteration per cycle, WIDTH cycles total
    // DONE  | single-cycle completion pulse; start here re-issues immediately

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_in;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] result;

    // Signed operands are reduced to magnitudes; 0x80..0 negates to itself,
    // which is the correct unsigned magnitude.
    always_comb begin
        mag_a  = (is_signed && inp_A[WIDTH-1]) ? -inp_A : inp_A;
        mag_b  = (is_signed && inp_B[WIDTH-1]) ? -inp_B : inp_B;
        neg_in = is_signed & (inp_A[WIDTH-1] ^ inp_B[WIDTH-1]);
    end

    // The add keeps its carry, which becomes the new MSB after the shift.
    always_comb begin
        addend   = mplier[0] ? {1'b0, mcand} : '0;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend;
        acc_next = {sum, acc[WIDTH-1:1]};
        result   = neg ? -acc_next : acc_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= neg_in;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        {hi, lo} <= result;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
